mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Pipeline MEM stage sitting directly upstream of the byte-lane data RAM.
- Accepts one memory-stage op per handshake, and drives the RAM chip-enable, write-enable, address, byte-select and write data.
- Waits out the RAM's one-cycle registered read, then aligns and sign/zero-extends load data.
- Presents a registered writeback record (register index, write flag, data) to the WB stage.

Parameters:
- ADDR_W, 32, byte address width on addr_i/mem_addr_o.
- DATA_W, 32, word width. Fixed at 32 in this version; other values are unsupported.
- REG_IDX_W, 5, destination register index width.

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- valid_i  in  1  upstream presents an op
- ready_o  out  1  unit can accept; equals (state==IDLE)
- mem_op_i  in  4  op code: NOP/LB/LBU/LH/LHU/LW/SB/SH/SW
- addr_i  in  ADDR_W  effective byte address
- store_data_i  in  DATA_W  rt value for stores
- wd_i  in  REG_IDX_W  destination register
- wreg_i  in  1  destination write enable
- wdata_i  in  DATA_W  ALU result, forwarded for NOP ops
- mem_ce_o  out  1  RAM chip enable
- mem_we_o  out  1  RAM write enable
- mem_addr_o  out  ADDR_W  RAM address
- mem_sel_o  out  4  RAM byte selects
- mem_data_o  out  DATA_W  RAM write data
- mem_data_i  in  DATA_W  RAM read word; valid the cycle after a read request
- wb_valid_o  out  1  writeback record valid, one-cycle pulse per op
- wd_o  out  REG_IDX_W  writeback register
- wreg_o  out  1  writeback enable
- wdata_o  out  DATA_W  writeback data

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE; wb_valid_o=0, wd_o=0, wreg_o=0, wdata_o=0.
- RAM outputs are combinational from state and inputs: mem_ce_o=0, mem_we_o=0, mem_addr_o=0, mem_sel_o=0, mem_data_o=0 unless a request is being issued.
- Accept: valid_i && ready_o at a posedge.
- Byte-lane map is big-endian:
  - byte: addr[1:0] 00→sel 1000, 01→0100, 10→0010, 11→0001.
  - half: addr[1]=0→1100, addr[1]=1→0011.
  - word: 1111.
- mem_addr_o = {addr_i[ADDR_W-1:2], 2'b00}.
- FSM has states IDLE and LOAD_WAIT.
- IDLE with NOP accepted:
  - no RAM access.
  - next cycle: wb_valid_o=1, wd/wreg/wdata = wd_i/wreg_i/wdata_i (latency 1).
- IDLE with store accepted:
  - same cycle: ce=1, we=1, sel per lane map.
  - mem_data_o replicates the source: SB {4{b[7:0]}}, SH {2{h[15:0]}}, SW word.
  - next cycle: wb_valid_o=1, wreg_o=0, wdata_o=0.
  - state stays IDLE, so back-to-back stores run 1/cycle.
- IDLE with load accepted:
  - same cycle: ce=1, we=0, sel=1111 (full-word read).
  - latch op, addr[1:0], wd_i, wreg_i; state→LOAD_WAIT.
- LOAD_WAIT:
  - ready_o=0, no RAM request.
  - capture formatted mem_data_i into wdata_o; state→IDLE.
  - wb_valid_o=1 in the following cycle, so load latency is 2 and loads run 1 per 2 cycles.
- Load formatting, with byte index k=addr[1:0] selecting bits [31-8k:24-8k]:
  - LB sign-extends the byte; LBU zero-extends it.
  - LH/LHU select [31:16] or [15:0] by addr[1], then sign- or zero-extend.
  - LW passes the word.
- No accept while in LOAD_WAIT: valid_i is ignored, and the upstream must hold its op.
- wb_valid_o is deasserted in any cycle not following a completed op. wd/wreg/wdata hold their last values; wreg_o is forced to 0 when wb_valid_o=0.
- rst asserted in LOAD_WAIT: return to IDLE, no writeback pulse. The discarded mem_data_i is ignored.
- rst in the same cycle as an accept: the accept is discarded.
- Undefined op codes are treated as NOP.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined: extra ports adel_o (load) and ades_o (store), 1 bit each.
  - A misaligned LH/LHU/SH (addr[0]=1) or LW/SW (addr[1:0]≠0) issues no RAM request (ce=0).
  - It completes in 1 cycle: wb_valid_o=1, wreg_o=0, and adel_o or ades_o pulses alongside it.
  - Both ports reset to 0.
- Undefined: no such ports; the low address bits below access size are ignored (word uses aligned address; halfword uses addr[1] only).

Decomposition:
- Shared define file holds the op encodings MEM_OP_NOP=0, LB=1, LBU=2, LH=3, LHU=4, LW=5, SB=6, SH=7, SW=8, plus MEM_OP_W=4.
- Also in the define file: state encodings, and sel constants SEL_B0..SEL_B3, SEL_H0, SEL_H1, SEL_W.
- One combinational sub-module, load_align: inputs are op, offset and raw word; output is the extended load data.
- The FSM, store-lane steering and writeback registers stay in mem_access_unit.

Test Plan:
- SW addr 0x10 data 0xAABBCCDD → same cycle ce=1 we=1 sel=1111 mem_addr=0x10 data=0xAABBCCDD; next cycle wb_valid=1 wreg=0.
- SB addr 0x13 data 0x000000EE → sel=0001, mem_data_o=0xEEEEEEEE.
- LB addr 0x11 with mem_data_i=0x1280FF00 on cycle T+1 → wdata_o=0xFFFFFF80 with wb_valid at T+2; LBU same → 0x00000080; ready_o=0 at T+1.
- LH addr 0x12 with mem_data_i=0x0000_8001 → wdata_o=0xFFFF8001; LHU → 0x00008001.
- Load accepted, rst pulsed during LOAD_WAIT → no wb_valid pulse, state IDLE, ready_o=1 next cycle; then NOP wd=3 wdata=0x5 → wb 1 cycle later.
- MEM_ALIGN_CHECK_EN: LW addr 0x02 → mem_ce_o stays 0, adel_o=1 with wb_valid=1 wreg=0 next cycle.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM stage: op codes, FSM states, byte-lane
// selects and small op-classification helpers.
package mem_access_unit_pkg;

  localparam int MEM_OP_W = 4;
  typedef logic [MEM_OP_W-1:0] mem_op_t;

  localparam mem_op_t MEM_OP_NOP = 4'd0;
  localparam mem_op_t MEM_OP_LB  = 4'd1;
  localparam mem_op_t MEM_OP_LBU = 4'd2;
  localparam mem_op_t MEM_OP_LH  = 4'd3;
  localparam mem_op_t MEM_OP_LHU = 4'd4;
  localparam mem_op_t MEM_OP_LW  = 4'd5;
  localparam mem_op_t MEM_OP_SB  = 4'd6;
  localparam mem_op_t MEM_OP_SH  = 4'd7;
  localparam mem_op_t MEM_OP_SW  = 4'd8;

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_LOAD_WAIT = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    CLS_NOP   = 2'd0,
    CLS_LOAD  = 2'd1,
    CLS_STORE = 2'd2
  } op_class_e;

  // Big-endian lanes: byte 0 lives in bits [31:24].
  localparam logic [3:0] SEL_B0 = 4'b1000;
  localparam logic [3:0] SEL_B1 = 4'b0100;
  localparam logic [3:0] SEL_B2 = 4'b0010;
  localparam logic [3:0] SEL_B3 = 4'b0001;
  localparam logic [3:0] SEL_H0 = 4'b1100;
  localparam logic [3:0] SEL_H1 = 4'b0011;
  localparam logic [3:0] SEL_W  = 4'b1111;

  // Undefined codes fall into the NOP class.
  function automatic op_class_e op_class(input mem_op_t op);
    case (op)
      MEM_OP_NOP:                                         return CLS_NOP;
      MEM_OP_LB, MEM_OP_LBU, MEM_OP_LH, MEM_OP_LHU, MEM_OP_LW: return CLS_LOAD;
      MEM_OP_SB, MEM_OP_SH, MEM_OP_SW:                    return CLS_STORE;
      default:                                            return CLS_NOP;
    endcase
  endfunction

  function automatic logic [3:0] store_sel(input mem_op_t op, input logic [1:0] off);
    case (op)
      MEM_OP_SB: begin
        case (off)
          2'b00:   return SEL_B0;
          2'b01:   return SEL_B1;
          2'b10:   return SEL_B2;
          default: return SEL_B3;
        endcase
      end
      MEM_OP_SH: return off[1] ? SEL_H1 : SEL_H0;
      default:   return SEL_W;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Load formatter: picks the addressed byte/half out of the big-endian RAM
// word and sign- or zero-extends it. Purely combinational.
module mem_access_unit_load_align
  import mem_access_unit_pkg::*;
(
  input  mem_op_t     op_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] word_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane extraction then extension.
  always_comb begin
    case (off_i)
      2'b00:   byte_sel = word_i[31:24];
      2'b01:   byte_sel = word_i[23:16];
      2'b10:   byte_sel = word_i[15:8];
      default: byte_sel = word_i[7:0];
    endcase
    half_sel = off_i[1] ? word_i[15:0] : word_i[31:16];
    case (op_i)
      MEM_OP_LB:  data_o = {{24{byte_sel[7]}}, byte_sel};
      MEM_OP_LBU: data_o = {24'h000000, byte_sel};
      MEM_OP_LH:  data_o = {{16{half_sel[15]}}, half_sel};
      MEM_OP_LHU: data_o = {16'h0000, half_sel};
      default:    data_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM pipeline stage in front of the byte-lane data RAM.
// Optional build macro MEM_ALIGN_CHECK_EN adds adel_o/ades_o and suppresses
// RAM access for misaligned halfword/word ops.
//
// state        | meaning
// ST_IDLE      | ready for an op; stores and NOPs complete from here
// ST_LOAD_WAIT | RAM read in flight; format mem_data_i into writeback
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int REG_IDX_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [MEM_OP_W-1:0]  mem_op_i,
  input  logic [ADDR_W-1:0]    addr_i,
  input  logic [DATA_W-1:0]    store_data_i,
  input  logic [REG_IDX_W-1:0] wd_i,
  input  logic                 wreg_i,
  input  logic [DATA_W-1:0]    wdata_i,
  output logic                 mem_ce_o,
  output logic                 mem_we_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic [3:0]           mem_sel_o,
  output logic [DATA_W-1:0]    mem_data_o,
  input  logic [DATA_W-1:0]    mem_data_i,
  output logic                 wb_valid_o,
  output logic [REG_IDX_W-1:0] wd_o,
  output logic                 wreg_o,
  output logic [DATA_W-1:0]    wdata_o
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic                 adel_o,
  output logic                 ades_o
`endif
);

  state_e              state_q, state_d;
  op_class_e           cls;
  logic                accept;
  logic                misalign;
  logic                issue_load;
  logic                issue_store;

  mem_op_t             ld_op_q, ld_op_d;
  logic [1:0]          ld_off_q, ld_off_d;
  logic [REG_IDX_W-1:0] ld_wd_q, ld_wd_d;
  logic                ld_wreg_q, ld_wreg_d;
  logic [31:0]         load_data;

  logic                wb_valid_q, wb_valid_d;
  logic [REG_IDX_W-1:0] wd_q, wd_d;
  logic                wreg_q, wreg_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  assign cls = op_class(mem_op_i);
  // A reset cycle never counts as an accept, so no RAM write escapes it.
  assign accept = valid_i && (state_q == ST_IDLE) && !rst;

`ifdef MEM_ALIGN_CHECK_EN
  logic adel_q, adel_d;
  logic ades_q, ades_d;
  // Halfwords need addr[0]=0, words need addr[1:0]=0.
  always_comb begin
    case (mem_op_i)
      MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: misalign = addr_i[0];
      MEM_OP_LW, MEM_OP_SW:             misalign = (addr_i[1:0] != 2'b00);
      default:                          misalign = 1'b0;
    endcase
  end
  assign adel_o = adel_q;
  assign ades_o = ades_q;
`else
  assign misalign = 1'b0;
`endif

  assign issue_load  = accept && (cls == CLS_LOAD)  && !misalign;
  assign issue_store = accept && (cls == CLS_STORE) && !misalign;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state: only an issued load leaves IDLE, and LOAD_WAIT lasts one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (issue_load) state_d = ST_LOAD_WAIT;
      ST_LOAD_WAIT: state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // FSM outputs and RAM request, all zero unless a request goes out now.
  always_comb begin
    ready_o    = (state_q == ST_IDLE);
    mem_ce_o   = issue_load || issue_store;
    mem_we_o   = issue_store;
    mem_addr_o = '0;
    mem_sel_o  = 4'b0000;
    mem_data_o = '0;
    if (issue_load || issue_store) begin
      mem_addr_o = {addr_i[ADDR_W-1:2], 2'b00};
    end
    if (issue_load) begin
      mem_sel_o = SEL_W;
    end else if (issue_store) begin
      mem_sel_o = store_sel(mem_op_i, addr_i[1:0]);
      case (mem_op_i)
        MEM_OP_SB: mem_data_o = {4{store_data_i[7:0]}};
        MEM_OP_SH: mem_data_o = {2{store_data_i[15:0]}};
        default:   mem_data_o = store_data_i;
      endcase
    end
  end

  mem_access_unit_load_align u_load_align (
    .op_i   (ld_op_q),
    .off_i  (ld_off_q),
    .word_i (mem_data_i),
    .data_o (load_data)
  );

  // Writeback record and pending-load context, next values.
  always_comb begin
    wb_valid_d = 1'b0;
    wd_d       = wd_q;
    wreg_d     = wreg_q;
    wdata_d    = wdata_q;
    ld_op_d    = ld_op_q;
    ld_off_d   = ld_off_q;
    ld_wd_d    = ld_wd_q;
    ld_wreg_d  = ld_wreg_q;
`ifdef MEM_ALIGN_CHECK_EN
    adel_d     = 1'b0;
    ades_d     = 1'b0;
`endif
    if (state_q == ST_LOAD_WAIT) begin
      wb_valid_d = 1'b1;
      wd_d       = ld_wd_q;
      wreg_d     = ld_wreg_q;
      wdata_d    = load_data;
    end else if (accept) begin
      if (misalign) begin
        wb_valid_d = 1'b1;
        wd_d       = wd_i;
        wreg_d     = 1'b0;
        wdata_d    = '0;
`ifdef MEM_ALIGN_CHECK_EN
        adel_d     = (cls == CLS_LOAD);
        ades_d     = (cls == CLS_STORE);
`endif
      end else begin
        case (cls)
          CLS_LOAD: begin
            ld_op_d   = mem_op_i;
            ld_off_d  = addr_i[1:0];
            ld_wd_d   = wd_i;
            ld_wreg_d = wreg_i;
          end
          CLS_STORE: begin
            wb_valid_d = 1'b1;
            wd_d       = wd_i;
            wreg_d     = 1'b0;
            wdata_d    = '0;
          end
          default: begin
            wb_valid_d = 1'b1;
            wd_d       = wd_i;
            wreg_d     = wreg_i;
            wdata_d    = wdata_i;
          end
        endcase
      end
    end
  end

  // Writeback and load-context registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_q <= 1'b0;
      wd_q       <= '0;
      wreg_q     <= 1'b0;
      wdata_q    <= '0;
      ld_op_q    <= MEM_OP_NOP;
      ld_off_q   <= 2'b00;
      ld_wd_q    <= '0;
      ld_wreg_q  <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      adel_q     <= 1'b0;
      ades_q     <= 1'b0;
`endif
    end else begin
      wb_valid_q <= wb_valid_d;
      wd_q       <= wd_d;
      wreg_q     <= wreg_d;
      wdata_q    <= wdata_d;
      ld_op_q    <= ld_op_d;
      ld_off_q   <= ld_off_d;
      ld_wd_q    <= ld_wd_d;
      ld_wreg_q  <= ld_wreg_d;
`ifdef MEM_ALIGN_CHECK_EN
      adel_q     <= adel_d;
      ades_q     <= ades_d;
`endif
    end
  end

  assign wb_valid_o = wb_valid_q;
  assign wd_o       = wd_q;
  assign wreg_o     = wreg_q & wb_valid_q;
  assign wdata_o    = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit. Inputs change 1 time unit after the
// rising edge; combinational RAM outputs are sampled before the next edge and
// registered writeback outputs 1 time unit after it.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic        ready_o;
  logic [3:0]  mem_op_i;
  logic [31:0] addr_i;
  logic [31:0] store_data_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic        mem_ce_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_sel_o;
  logic [31:0] mem_data_o;
  logic [31:0] mem_data_i;
  logic        wb_valid_o;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
`ifdef MEM_ALIGN_CHECK_EN
  logic        adel_o;
  logic        ades_o;
`endif

  int nchk = 0;
  int nerr = 0;

  mem_access_unit dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .mem_op_i     (mem_op_i),
    .addr_i       (addr_i),
    .store_data_i (store_data_i),
    .wd_i         (wd_i),
    .wreg_i       (wreg_i),
    .wdata_i      (wdata_i),
    .mem_ce_o     (mem_ce_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_sel_o    (mem_sel_o),
    .mem_data_o   (mem_data_o),
    .mem_data_i   (mem_data_i),
    .wb_valid_o   (wb_valid_o),
    .wd_o         (wd_o),
    .wreg_o       (wreg_o),
    .wdata_o      (wdata_o)
`ifdef MEM_ALIGN_CHECK_EN
    ,
    .adel_o       (adel_o),
    .ades_o       (ades_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_i = 1'b0; mem_op_i = 4'd0; addr_i = '0; store_data_i = '0;
    wd_i = '0; wreg_i = 1'b0; wdata_i = '0; mem_data_i = '0;
    step(); step();
    nchk++; if (wb_valid_o !== 1'b0) begin nerr++; $display("FAIL rst_wb_valid got=%h exp=0", wb_valid_o); end
    nchk++; if (wd_o !== 5'd0) begin nerr++; $display("FAIL rst_wd got=%h exp=0", wd_o); end
    nchk++; if (wreg_o !== 1'b0) begin nerr++; $display("FAIL rst_wreg got=%h exp=0", wreg_o); end
    nchk++; if (wdata_o !== 32'h0) begin nerr++; $display("FAIL rst_wdata got=%h exp=0", wdata_o); end
    nchk++; if (ready_o !== 1'b1) begin nerr++; $display("FAIL rst_ready got=%h exp=1", ready_o); end
    nchk++; if ({mem_ce_o, mem_we_o, mem_sel_o} !== 6'b0) begin nerr++; $display("FAIL rst_ram got=%b exp=000000", {mem_ce_o, mem_we_o, mem_sel_o}); end
    rst = 1'b0;
  endtask

  task automatic test_store_word();
    valid_i = 1'b1; mem_op_i = 4'd8; addr_i = 32'h10; store_data_i = 32'hAABBCCDD;
    wd_i = 5'd7; wreg_i = 1'b1;
    #1;
    nchk++; if ({mem_ce_o, mem_we_o} !== 2'b11) begin nerr++; $display("FAIL sw_ce_we got=%b exp=11", {mem_ce_o, mem_we_o}); end
    nchk++; if (mem_sel_o !== 4'b1111) begin nerr++; $display("FAIL sw_sel got=%b exp=1111", mem_sel_o); end
    nchk++; if (mem_addr_o !== 32'h10) begin nerr++; $display("FAIL sw_addr got=%h exp=00000010", mem_addr_o); end
    nchk++; if (mem_data_o !== 32'hAABBCCDD) begin nerr++; $display("FAIL sw_data got=%h exp=aabbccdd", mem_data_o); end
    step();
    valid_i = 1'b0;
    nchk++; if (wb_valid_o !== 1'b1) begin nerr++; $display("FAIL sw_wb_valid got=%h exp=1", wb_valid_o); end
    nchk++; if (wreg_o !== 1'b0) begin nerr++; $display("FAIL sw_wreg got=%h exp=0", wreg_o); end
    nchk++; if (wdata_o !== 32'h0) begin nerr++; $display("FAIL sw_wdata got=%h exp=0", wdata_o); end
    #1;
    nchk++; if ({mem_ce_o, mem_we_o, mem_addr_o, mem_sel_o, mem_data_o} !== '0) begin nerr++; $display("FAIL idle_ram_zero ce=%h we=%h addr=%h sel=%b data=%h exp all 0", mem_ce_o, mem_we_o, mem_addr_o, mem_sel_o, mem_data_o); end
    step();
    nchk++; if (wb_valid_o !== 1'b0) begin nerr++; $display("FAIL sw_wb_drop got=%h exp=0", wb_valid_o); end
  endtask

  task automatic test_back_to_back();
    valid_i = 1'b1; mem_op_i = 4'd6; addr_i = 32'h13; store_data_i = 32'h000000EE;
    #1;
    nchk++; if (mem_sel_o !== 4'b0001) begin nerr++; $display("FAIL sb_sel got=%b exp=0001", mem_sel_o); end
    nchk++; if (mem_data_o !== 32'hEEEEEEEE) begin nerr++; $display("FAIL sb_data got=%h exp=eeeeeeee", mem_data_o); end
    nchk++; if (mem_addr_o !== 32'h10) begin nerr++; $display("FAIL sb_addr got=%h exp=00000010", mem_addr_o); end
    step();
    mem_op_i = 4'd7; addr_i = 32'h22; store_data_i = 32'hFFFF1234;
    #1;
    nchk++; if (ready_o !== 1'b1) begin nerr++; $display("FAIL b2b_ready got=%h exp=1", ready_o); end
    nchk++; if ({mem_ce_o, mem_we_o, mem_sel_o} !== 6'b110011) begin nerr++; $display("FAIL sh_ce_we_sel got=%b exp=110011", {mem_ce_o, mem_we_o, mem_sel_o}); end
    nchk++; if (mem_data_o !== 32'h12341234) begin nerr++; $display("FAIL sh_data got=%h exp=12341234", mem_data_o); end
    nchk++; if (mem_addr_o !== 32'h20) begin nerr++; $display("FAIL sh_addr got=%h exp=00000020", mem_addr_o); end
    step();
    mem_op_i = 4'd6; addr_i = 32'h21; store_data_i = 32'h0000005A;
    #1;
    nchk++; if (mem_sel_o !== 4'b0100) begin nerr++; $display("FAIL sb1_sel got=%b exp=0100", mem_sel_o); end
    nchk++; if (wb_valid_o !== 1'b1) begin nerr++; $display("FAIL b2b_wb_valid got=%h exp=1", wb_valid_o); end
    step();
    valid_i = 1'b0;
    nchk++; if (wb_valid_o !== 1'b1) begin nerr++; $display("FAIL b2b_wb_valid3 got=%h exp=1", wb_valid_o); end
    step();
  endtask

  task automatic test_loads();
    logic [3:0]  ops   [8] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd1, 4'd2, 4'd3};
    logic [31:0] addrs [8] = '{32'h11, 32'h11, 32'h12, 32'h12, 32'h17, 32'h10, 32'h13, 32'h10};
    logic [31:0] words [8] = '{32'h1280FF00, 32'h1280FF00, 32'h00008001, 32'h00008001,
                               32'hDEADBEEF, 32'h7F001234, 32'h000000C3, 32'h7FFE1234};
    logic [31:0] exps  [8] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001,
                               32'hDEADBEEF, 32'h0000007F, 32'h000000C3, 32'h00007FFE};
    for (int i = 0; i < 8; i++) begin
      valid_i = 1'b1; mem_op_i = ops[i]; addr_i = addrs[i]; wd_i = 5'(i + 9); wreg_i = 1'b1;
      mem_data_i = 32'h0;
      #1;
      nchk++; if ({mem_ce_o, mem_we_o, mem_sel_o} !== 6'b101111) begin nerr++; $display("FAIL ld%0d_req got=%b exp=101111", i, {mem_ce_o, mem_we_o, mem_sel_o}); end
      nchk++; if (mem_addr_o !== {addrs[i][31:2], 2'b00}) begin nerr++; $display("FAIL ld%0d_addr got=%h exp=%h", i, mem_addr_o, {addrs[i][31:2], 2'b00}); end
      step();
      // upstream presents a store that must be ignored while the read is pending
      mem_op_i = 4'd8; addr_i = 32'h40; mem_data_i = words[i];
      #1;
      nchk++; if ({ready_o, mem_ce_o, wb_valid_o} !== 3'b000) begin nerr++; $display("FAIL ld%0d_wait got=%b exp=000", i, {ready_o, mem_ce_o, wb_valid_o}); end
      step();
      valid_i = 1'b0; mem_data_i = 32'h55AA55AA;
      nchk++; if (wb_valid_o !== 1'b1) begin nerr++; $display("FAIL ld%0d_wb_valid got=%h exp=1", i, wb_valid_o); end
      nchk++; if (wdata_o !== exps[i]) begin nerr++; $display("FAIL ld%0d_wdata got=%h exp=%h", i, wdata_o, exps[i]); end
      nchk++; if ({wreg_o, wd_o} !== {1'b1, 5'(i + 9)}) begin nerr++; $display("FAIL ld%0d_wreg_wd got=%h exp=%h", i, {wreg_o, wd_o}, {1'b1, 5'(i + 9)}); end
      nchk++; if (ready_o !== 1'b1) begin nerr++; $display("FAIL ld%0d_ready got=%h exp=1", i, ready_o); end
    end
    step();
    nchk++; if (wb_valid_o !== 1'b0) begin nerr++; $display("FAIL ld_no_extra_wb got=%h exp=0", wb_valid_o); end
  endtask

  task automatic test_reset_in_load();
    valid_i = 1'b1; mem_op_i = 4'd5; addr_i = 32'h30; wd_i = 5'd12; wreg_i = 1'b1;
    step();
    valid_i = 1'b0; rst = 1'b1; mem_data_i = 32'hBADBAD00;
    step();
    rst = 1'b0;
    nchk++; if (wb_valid_o !== 1'b0) begin nerr++; $display("FAIL rstld_wb got=%h exp=0", wb_valid_o); end
    nchk++; if (ready_o !== 1'b1) begin nerr++; $display("FAIL rstld_ready got=%h exp=1", ready_o); end
    step();
    nchk++; if (wb_valid_o !== 1'b0) begin nerr++; $display("FAIL rstld_late_wb got=%h exp=0", wb_valid_o); end
    valid_i = 1'b1; mem_op_i = 4'd0; wd_i = 5'd3; wreg_i = 1'b1; wdata_i = 32'h5;
    #1;
    nchk++; if (mem_ce_o !== 1'b0) begin nerr++; $display("FAIL nop_ce got=%h exp=0", mem_ce_o); end
    step();
    valid_i = 1'b0;
    nchk++; if ({wb_valid_o, wreg_o, wd_o, wdata_o} !== {1'b1, 1'b1, 5'd3, 32'h5}) begin nerr++; $display("FAIL nop_wb got=%h exp=%h", {wb_valid_o, wreg_o, wd_o, wdata_o}, {1'b1, 1'b1, 5'd3, 32'h5}); end
    step();
    nchk++; if ({wb_valid_o, wreg_o, wd_o, wdata_o} !== {1'b0, 1'b0, 5'd3, 32'h5}) begin nerr++; $display("FAIL nop_hold got=%h exp=%h", {wb_valid_o, wreg_o, wd_o, wdata_o}, {1'b0, 1'b0, 5'd3, 32'h5}); end
  endtask

  task automatic test_reset_with_accept();
    rst = 1'b1; valid_i = 1'b1; mem_op_i = 4'd8; addr_i = 32'h50; store_data_i = 32'h11223344;
    #1;
    nchk++; if (mem_ce_o !== 1'b0) begin nerr++; $display("FAIL rstacc_ce got=%h exp=0", mem_ce_o); end
    step();
    rst = 1'b0; valid_i = 1'b0;
    nchk++; if (wb_valid_o !== 1'b0) begin nerr++; $display("FAIL rstacc_wb got=%h exp=0", wb_valid_o); end
  endtask

  task automatic test_undef_op();
    valid_i = 1'b1; mem_op_i = 4'hF; addr_i = 32'h60; wd_i = 5'd21; wreg_i = 1'b1; wdata_i = 32'hCAFEF00D;
    #1;
    nchk++; if (mem_ce_o !== 1'b0) begin nerr++; $display("FAIL undef_ce got=%h exp=0", mem_ce_o); end
    step();
    valid_i = 1'b0;
    nchk++; if ({wb_valid_o, wreg_o, wd_o, wdata_o} !== {1'b1, 1'b1, 5'd21, 32'hCAFEF00D}) begin nerr++; $display("FAIL undef_wb got=%h exp=%h", {wb_valid_o, wreg_o, wd_o, wdata_o}, {1'b1, 1'b1, 5'd21, 32'hCAFEF00D}); end
    nchk++; if (ready_o !== 1'b1) begin nerr++; $display("FAIL undef_ready got=%h exp=1", ready_o); end
    step();
  endtask

  task automatic test_align();
`ifdef MEM_ALIGN_CHECK_EN
    valid_i = 1'b1; mem_op_i = 4'd5; addr_i = 32'h02; wd_i = 5'd4; wreg_i = 1'b1;
    #1;
    nchk++; if (mem_ce_o !== 1'b0) begin nerr++; $display("FAIL adel_ce got=%h exp=0", mem_ce_o); end
    step();
    mem_op_i = 4'd7; addr_i = 32'h13;
    nchk++; if ({wb_valid_o, wreg_o, adel_o, ades_o} !== 4'b1010) begin nerr++; $display("FAIL adel_wb got=%b exp=1010", {wb_valid_o, wreg_o, adel_o, ades_o}); end
    nchk++; if (ready_o !== 1'b1) begin nerr++; $display("FAIL adel_ready got=%h exp=1", ready_o); end
    #1;
    nchk++; if (mem_ce_o !== 1'b0) begin nerr++; $display("FAIL ades_ce got=%h exp=0", mem_ce_o); end
    step();
    valid_i = 1'b0;
    nchk++; if ({wb_valid_o, wreg_o, adel_o, ades_o} !== 4'b1001) begin nerr++; $display("FAIL ades_wb got=%b exp=1001", {wb_valid_o, wreg_o, adel_o, ades_o}); end
    step();
    nchk++; if ({wb_valid_o, adel_o, ades_o} !== 3'b000) begin nerr++; $display("FAIL align_drop got=%b exp=000", {wb_valid_o, adel_o, ades_o}); end
`else
    valid_i = 1'b1; mem_op_i = 4'd5; addr_i = 32'h02; wd_i = 5'd4; wreg_i = 1'b1;
    #1;
    nchk++; if ({mem_ce_o, mem_sel_o, mem_addr_o} !== {1'b1, 4'b1111, 32'h0}) begin nerr++; $display("FAIL unal_lw_req got=%h exp=%h", {mem_ce_o, mem_sel_o, mem_addr_o}, {1'b1, 4'b1111, 32'h0}); end
    step();
    valid_i = 1'b0; mem_data_i = 32'h89ABCDEF;
    step();
    nchk++; if ({wb_valid_o, wreg_o, wdata_o} !== {1'b1, 1'b1, 32'h89ABCDEF}) begin nerr++; $display("FAIL unal_lw_wb got=%h exp=%h", {wb_valid_o, wreg_o, wdata_o}, {1'b1, 1'b1, 32'h89ABCDEF}); end
    valid_i = 1'b1; mem_op_i = 4'd7; addr_i = 32'h13; store_data_i = 32'h0000ABCD;
    #1;
    nchk++; if ({mem_ce_o, mem_we_o, mem_sel_o, mem_data_o} !== {1'b1, 1'b1, 4'b0011, 32'hABCDABCD}) begin nerr++; $display("FAIL unal_sh_req got=%h exp=%h", {mem_ce_o, mem_we_o, mem_sel_o, mem_data_o}, {1'b1, 1'b1, 4'b0011, 32'hABCDABCD}); end
    step();
    valid_i = 1'b0;
    step();
`endif
  endtask

  initial begin
    #1;
    test_reset();
    test_store_word();
    test_back_to_back();
    test_loads();
    test_reset_in_load();
    test_reset_with_accept();
    test_undef_op();
    test_align();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
